io_peripheral: RTL and testbench
================================

# io_peripheral

Memory-mapped I/O peripheral block that sits directly downstream of the load/store address decoder. It receives the decoder's I/O valid and write-enable flags together with the LSU address, write data and byte mask. Output-device registers (LEDs, seven-segment, LCD) are held here with byte-lane writes. Switch and key inputs are synchronised and optionally debounced, and reads of any I/O register return registered data to the LSU load path.

## Interface
Parameters:
- SW_WIDTH, 18, number of slide-switch inputs.
- KEY_WIDTH, 4, number of push-button inputs.
- DEBOUNCE_CYCLES, 500000, number of cycles an input must be stable before it is accepted. Must be ≥ 2.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_lsu_addr  in  32  load/store address.
- i_lsu_wdata  in  32  store data.
- i_lsu_bmask  in  4  byte-lane enables; bit n enables byte n.
- f_io_valid  in  1  address falls in 0x1000_xxxx or 0x1001_xxxx.
- f_io_wren  in  1  store to the I/O region.
- i_io_sw  in  SW_WIDTH  raw switches; asynchronous.
- i_io_key  in  KEY_WIDTH  raw keys; asynchronous; active-low at the pin.
- o_io_rdata  out  32  registered load data.
- o_io_ledr  out  32  red LED register.
- o_io_ledg  out  32  green LED register.
- o_io_hex0 … o_io_hex7  out  7 each  seven-segment digits.
- o_io_lcd  out  32  LCD control register.

## Operation
- Register select is i_lsu_addr[15:12] within the region:
  - 0x1000_0xxx: LEDR
  - 0x1000_1xxx: LEDG
  - 0x1000_2xxx: HEX_LO (bytes 0–3 map to hex0–3, bits [6:0] of each byte)
  - 0x1000_3xxx: HEX_HI (hex4–7)
  - 0x1000_4xxx: LCD
  - 0x1001_0xxx: SW (read-only)
  - 0x1001_1xxx: KEY (read-only)
- Address bits [11:0] are ignored; aliases of the same register are accepted.
- Write (f_io_wren=1, output region): each byte n of the selected register is loaded from i_lsu_wdata[8n+7:8n] when i_lsu_bmask[n]=1. Other bytes hold.
- Writes to the 0x1001 region or to unmapped selects are discarded with no side effects.
- Read (f_io_valid=1, f_io_wren=0): the full 32-bit selected register is captured into o_io_rdata. The LSU applies byte/halfword extraction.
  - SW reads are zero-extended.
  - KEY reads are inverted to active-high and zero-extended.
  - Unmapped selects read 0.
- When f_io_valid=0, or on a write cycle, o_io_rdata is loaded with 0.
- f_io_wren=1 with f_io_valid=0 is treated as no access.
- Inputs pass through a 2-FF synchroniser before any other use.
- HEX bit 7 of each byte is stored and read back but not driven out.

## Timing
- Reset: all output registers, o_io_rdata, synchroniser flops, stable input values and debounce counters clear to 0.
  - Stable KEY value resets to all-ones (released), so a KEY read returns 0.
  - A write asserted in the same cycle as i_reset is not performed.
- Write latency: the register output updates on the edge that samples the write and is visible on the next cycle.
- Read latency: 1 cycle. o_io_rdata is valid the cycle after the request.
- Back-to-back write then read of the same register returns the new value.
- Input latency:
  - 2 cycles (synchroniser) without debounce.
  - With debounce, 2 + DEBOUNCE_CYCLES cycles.

## Configuration
- Macro: IO_DEBOUNCE_EN.
- When defined, each input bit has its own counter of width $clog2(DEBOUNCE_CYCLES):
  - Synchronised value equal to the stable value: counter clears.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1 the stable value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable value.
- When not defined, no counters exist and the stable value equals the synchroniser output.

## Test plan
- Reset: assert i_reset for 2 cycles → all LED/HEX/LCD outputs 0, o_io_rdata 0; KEY read returns 0x0000_0000.
- Byte-lane write: write 0xAABBCCDD with bmask 0xF to 0x1000_0000, then write 0x0000_1100 with bmask 0x2 → o_io_ledr = 0xAABB11DD; a read of 0x1000_0ABC returns 0xAABB11DD one cycle later.
- HEX mapping: write 0x0F7F_0140 to 0x1000_3000 → hex7=0x0F, hex6=0x7F, hex5=0x01, hex4=0x40; hex0–3 unchanged.
- Read-only and unmapped: write 0xFFFF_FFFF to 0x1001_0000 and to 0x1000_9000 → no output changes; reading 0x1000_9000 returns 0.
- Input path with DEBOUNCE_CYCLES=4 and IO_DEBOUNCE_EN defined:
  - Drive i_io_sw=0x3 for 3 cycles then 0 → SW read stays 0.
  - Hold 0x3 → SW read returns 0x3 no later than 2+4+1 cycles after the change.
  - Without the macro, a SW read returns 0x3 after 2 cycles.
- Key polarity: drive i_io_key=4'b1110 (key0 pressed) and let it settle → read of 0x1001_1000 returns 0x1.

Source files
------------

// File: rtl/io_peripheral.sv
// Memory-mapped LED/HEX/LCD output registers and synchronised SW/KEY inputs for the LSU.
// Optional per-bit input debounce is enabled by defining IO_DEBOUNCE_EN.
module io_peripheral #(
   parameter int SW_WIDTH        = 18,
   parameter int KEY_WIDTH       = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [31:0]          i_lsu_addr,
   input  logic [31:0]          i_lsu_wdata,
   input  logic [3:0]           i_lsu_bmask,
   input  logic                 f_io_valid,
   input  logic                 f_io_wren,
   input  logic [SW_WIDTH-1:0]  i_io_sw,
   input  logic [KEY_WIDTH-1:0] i_io_key,
   output logic [31:0]          o_io_rdata,
   output logic [31:0]          o_io_ledr,
   output logic [31:0]          o_io_ledg,
   output logic [6:0]           o_io_hex0,
   output logic [6:0]           o_io_hex1,
   output logic [6:0]           o_io_hex2,
   output logic [6:0]           o_io_hex3,
   output logic [6:0]           o_io_hex4,
   output logic [6:0]           o_io_hex5,
   output logic [6:0]           o_io_hex6,
   output logic [6:0]           o_io_hex7,
   output logic [31:0]          o_io_lcd
);

   localparam logic [3:0] SEL_LEDR   = 4'h0;
   localparam logic [3:0] SEL_LEDG   = 4'h1;
   localparam logic [3:0] SEL_HEX_LO = 4'h2;
   localparam logic [3:0] SEL_HEX_HI = 4'h3;
   localparam logic [3:0] SEL_LCD    = 4'h4;
   localparam logic [3:0] SEL_SW     = 4'h0;
   localparam logic [3:0] SEL_KEY    = 4'h1;

   logic [31:0] hex_lo, hex_hi;
   logic [3:0]  sel;
   logic        out_region, in_region, wr_en;
   logic [31:0] rd_mux;
   logic        unused_addr;

   logic [SW_WIDTH-1:0]  sw_meta, sw_sync, sw_stable;
   logic [KEY_WIDTH-1:0] key_meta, key_sync, key_stable;

   assign sel         = i_lsu_addr[15:12];
   assign out_region  = (i_lsu_addr[31:16] == 16'h1000);
   assign in_region   = (i_lsu_addr[31:16] == 16'h1001);
   assign wr_en       = f_io_valid & f_io_wren & out_region;
   assign unused_addr = ^i_lsu_addr[11:0];

   function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wdata,
                                         input logic [3:0] bmask);
      logic [31:0] res;
      res = old_val;
      for (int n = 0; n < 4; n++)
         if (bmask[n]) res[8*n +: 8] = wdata[8*n +: 8];
      return res;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_io_ledr <= '0;
         o_io_ledg <= '0;
         hex_lo    <= '0;
         hex_hi    <= '0;
         o_io_lcd  <= '0;
      end else if (wr_en) begin
         case (sel)
            SEL_LEDR:   o_io_ledr <= merge(o_io_ledr, i_lsu_wdata, i_lsu_bmask);
            SEL_LEDG:   o_io_ledg <= merge(o_io_ledg, i_lsu_wdata, i_lsu_bmask);
            SEL_HEX_LO: hex_lo    <= merge(hex_lo, i_lsu_wdata, i_lsu_bmask);
            SEL_HEX_HI: hex_hi    <= merge(hex_hi, i_lsu_wdata, i_lsu_bmask);
            SEL_LCD:    o_io_lcd  <= merge(o_io_lcd, i_lsu_wdata, i_lsu_bmask);
            default:    ;
         endcase
      end
   end

   // Bit 7 of each HEX byte is kept for read-back only.
   assign o_io_hex0 = hex_lo[6:0];
   assign o_io_hex1 = hex_lo[14:8];
   assign o_io_hex2 = hex_lo[22:16];
   assign o_io_hex3 = hex_lo[30:24];
   assign o_io_hex4 = hex_hi[6:0];
   assign o_io_hex5 = hex_hi[14:8];
   assign o_io_hex6 = hex_hi[22:16];
   assign o_io_hex7 = hex_hi[30:24];

   // Key flops reset to the released (high) pin level so a KEY read after reset is 0.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= '1;
         key_sync <= '1;
      end else begin
         sw_meta  <= i_io_sw;
         sw_sync  <= sw_meta;
         key_meta <= i_io_key;
         key_sync <= key_meta;
      end
   end

`ifdef IO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] sw_cnt  [SW_WIDTH];
   logic [CW-1:0] key_cnt [KEY_WIDTH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sw_stable  <= '0;
         key_stable <= '1;
         for (int i = 0; i < SW_WIDTH; i++)  sw_cnt[i]  <= '0;
         for (int i = 0; i < KEY_WIDTH; i++) key_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < SW_WIDTH; i++) begin
            if (sw_sync[i] == sw_stable[i]) sw_cnt[i] <= '0;
            else if (sw_cnt[i] == CNT_LAST) begin
               sw_stable[i] <= sw_sync[i];
               sw_cnt[i]    <= '0;
            end else sw_cnt[i] <= sw_cnt[i] + 1'b1;
         end
         for (int i = 0; i < KEY_WIDTH; i++) begin
            if (key_sync[i] == key_stable[i]) key_cnt[i] <= '0;
            else if (key_cnt[i] == CNT_LAST) begin
               key_stable[i] <= key_sync[i];
               key_cnt[i]    <= '0;
            end else key_cnt[i] <= key_cnt[i] + 1'b1;
         end
      end
   end
`else
   assign sw_stable  = sw_sync;
   assign key_stable = key_sync;
`endif

   always_comb begin
      rd_mux = '0;
      if (out_region) begin
         case (sel)
            SEL_LEDR:   rd_mux = o_io_ledr;
            SEL_LEDG:   rd_mux = o_io_ledg;
            SEL_HEX_LO: rd_mux = hex_lo;
            SEL_HEX_HI: rd_mux = hex_hi;
            SEL_LCD:    rd_mux = o_io_lcd;
            default:    rd_mux = '0;
         endcase
      end else if (in_region) begin
         if (sel == SEL_SW)  rd_mux[SW_WIDTH-1:0]  = sw_stable;
         if (sel == SEL_KEY) rd_mux[KEY_WIDTH-1:0] = ~key_stable;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) o_io_rdata <= '0;
      else if (f_io_valid && !f_io_wren) o_io_rdata <= rd_mux;
      else o_io_rdata <= '0;
   end

endmodule

// File: tb/tb_io_peripheral.sv
// Directed bench for io_peripheral: register writes, byte lanes, reads, decode and input path.
module tb_io_peripheral;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata;
   logic [3:0]  bmask;
   logic        valid, wren;
   logic [17:0] sw;
   logic [3:0]  key;
   logic [31:0] rdata, ledr, ledg, lcd;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

   int checks = 0;
   int passes = 0;

   io_peripheral #(.SW_WIDTH(18), .KEY_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_lsu_addr(addr), .i_lsu_wdata(wdata),
      .i_lsu_bmask(bmask), .f_io_valid(valid), .f_io_wren(wren),
      .i_io_sw(sw), .i_io_key(key), .o_io_rdata(rdata),
      .o_io_ledr(ledr), .o_io_ledg(ledg),
      .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
      .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
      .o_io_lcd(lcd)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      addr = a; wdata = d; bmask = m; valid = 1'b1; wren = 1'b1;
      tick();
   endtask

   task automatic rd(input logic [31:0] a);
      addr = a; wdata = '0; bmask = 4'h0; valid = 1'b1; wren = 1'b0;
      tick();
   endtask

   task automatic idle();
      valid = 1'b0; wren = 1'b0; bmask = 4'h0;
   endtask

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [159:0] snap();
      return {ledr, ledg, lcd, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   logic [159:0] exp_snap;

   initial begin
      reset = 1'b1; sw = '0; key = 4'hF;
      addr = 32'h1000_0000; wdata = 32'hFFFF_FFFF; bmask = 4'hF; valid = 1'b1; wren = 1'b1;
      ticks(2);
      reset = 1'b0;
      idle();
      check("reset_outputs", snap(), '0);
      check("reset_rdata", {128'b0, rdata}, '0);
      ticks(3);
      rd(32'h1001_1000);
      check("key_after_reset", {128'b0, rdata}, '0);

      wr(32'h1000_0000, 32'hAABB_CCDD, 4'hF);
      check("ledr_full", {128'b0, ledr}, {128'b0, 32'hAABB_CCDD});
      wr(32'h1000_0000, 32'h0000_1100, 4'h2);
      check("ledr_lane1", {128'b0, ledr}, {128'b0, 32'hAABB_11DD});
      rd(32'h1000_0ABC);
      check("ledr_alias_read", {128'b0, rdata}, {128'b0, 32'hAABB_11DD});

      wr(32'h1000_1000, 32'h1234_5678, 4'h5);
      check("rdata_on_write", {128'b0, rdata}, '0);
      check("ledg_lanes", {128'b0, ledg}, {128'b0, 32'h0034_0078});
      rd(32'h1000_1FFC);
      check("ledg_b2b_read", {128'b0, rdata}, {128'b0, 32'h0034_0078});
      idle();
      tick();
      check("rdata_idle", {128'b0, rdata}, '0);

      wr(32'h1000_2000, 32'h8011_2233, 4'hF);
      check("hex_lo", {132'b0, hex3, hex2, hex1, hex0}, {132'b0, 7'h00, 7'h11, 7'h22, 7'h33});
      rd(32'h1000_2000);
      check("hex_lo_bit7_read", {128'b0, rdata}, {128'b0, 32'h8011_2233});
      wr(32'h1000_3000, 32'h0F7F_0140, 4'hF);
      check("hex_hi", {132'b0, hex7, hex6, hex5, hex4}, {132'b0, 7'h0F, 7'h7F, 7'h01, 7'h40});
      check("hex_lo_held", {132'b0, hex3, hex2, hex1, hex0}, {132'b0, 7'h00, 7'h11, 7'h22, 7'h33});
      wr(32'h1000_4000, 32'hDEAD_BEEF, 4'hC);
      check("lcd_upper", {128'b0, lcd}, {128'b0, 32'hDEAD_0000});

      exp_snap = {32'hAABB_11DD, 32'h0034_0078, 32'hDEAD_0000,
                  7'h0F, 7'h7F, 7'h01, 7'h40, 7'h00, 7'h11, 7'h22, 7'h33};
      wr(32'h1001_0000, 32'hFFFF_FFFF, 4'hF);
      wr(32'h1000_9000, 32'hFFFF_FFFF, 4'hF);
      check("ro_unmapped_write", snap(), exp_snap);
      addr = 32'h1000_0000; wdata = 32'h0; bmask = 4'hF; valid = 1'b0; wren = 1'b1;
      tick();
      check("wren_without_valid", snap(), exp_snap);
      rd(32'h1000_0000);
      check("ledr_read", {128'b0, rdata}, {128'b0, 32'hAABB_11DD});
      rd(32'h1000_9000);
      check("unmapped_read", {128'b0, rdata}, '0);
      idle();

`ifdef IO_DEBOUNCE_EN
      sw = 18'h3;
      ticks(3);
      sw = 18'h0;
      ticks(10);
      rd(32'h1001_0000);
      check("sw_glitch", {128'b0, rdata}, '0);
      idle();
      sw = 18'h3;
      ticks(5);
      rd(32'h1001_0000);
      check("sw_early", {128'b0, rdata}, '0);
      rd(32'h1001_0000);
      check("sw_debounced", {128'b0, rdata}, {128'b0, 32'h3});
`else
      sw = 18'h3;
      tick();
      rd(32'h1001_0000);
      check("sw_early", {128'b0, rdata}, '0);
      rd(32'h1001_0000);
      check("sw_synced", {128'b0, rdata}, {128'b0, 32'h3});
`endif
      idle();

      key = 4'b1110;
      ticks(12);
      rd(32'h1001_1000);
      check("key_polarity", {128'b0, rdata}, {128'b0, 32'h1});
      idle();

      sw = 18'h2_A5A5;
      ticks(12);
      rd(32'h1001_0004);
      check("sw_zero_ext", {128'b0, rdata}, {128'b0, 32'h0002_A5A5});
      idle();
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
